// File: rtl/ysyx_24100029_pipe_skid.sv
// Two-entry valid/ready pipeline stage (main + skid register) with flush.
// in_ready, out_valid and level decode only from the state register, so no input reaches them combinationally.
module ysyx_24100029_pipe_skid #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  // Encoding equals occupancy, so level is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             accept, pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= EMPTY;
      main_reg  <= RESET_VAL;
      skid_reg  <= RESET_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // Data registers are left untouched; only occupancy is discarded.
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_next  = in_data;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (accept && pop) begin
            main_next = in_data;
          end else if (accept) begin
            skid_next  = in_data;
            state_next = FULL;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_next  = skid_reg;
            state_next = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    level     = 2'd0;
    case (state_reg)
      BUSY: begin
        out_valid = 1'b1;
        level     = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        level     = 2'd2;
      end
      default: ;
    endcase
  end

  assign out_data = main_reg;

endmodule

// File: tb/tb_ysyx_24100029_pipe_skid.sv
// Bench for ysyx_24100029_pipe_skid: queue reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ysyx_24100029_pipe_skid;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0]  level;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  logic [31:0] q[$];
  logic [31:0] last_out;

  ysyx_24100029_pipe_skid #(.WIDTH(32), .RESET_VAL(RV)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of at most two beats; acceptance depends only on the
  // occupancy before the edge.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      last_out = RV;
    end else if (flush) begin
      q.delete();
    end else begin
      automatic bit do_pop = (q.size() > 0) && out_ready;
      automatic bit do_acc = in_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(in_data);
      if (q.size() > 0) last_out = q[0];
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("m_level", {30'd0, level}, q.size());
      chk("m_out_data", out_data, last_out);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_out_data", out_data, 32'hDEAD_BEEF);
    check_en = 1'b1;
    $display("reset: out_valid=%0b in_ready=%0b level=%0d out_data=%h", out_valid, in_ready, level, out_data);

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      next_cycle();
      chk("str_valid", {31'd0, out_valid}, 32'd1);
      chk("str_data", out_data, i);
      chk("str_level", {30'd0, level}, 32'd1);
      chk("str_in_ready", {31'd0, in_ready}, 32'd1);
      $display("stream: beat %h out=%h level=%0d", i, out_data, level);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    chk("str_drain_level", {30'd0, level}, 32'd0);

    // Stall / skid
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    next_cycle();
    chk("stl_a", out_data, 32'hA);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    next_cycle();
    chk("stl_full_level", {30'd0, level}, 32'd2);
    chk("stl_full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    next_cycle();
    chk("stl_c_held_level", {30'd0, level}, 32'd2);
    chk("stl_head_a", out_data, 32'hA);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    next_cycle();
    chk("stl_head_b", out_data, 32'hB);
    chk("stl_rel_level", {30'd0, level}, 32'd1);
    chk("stl_rel_in_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();
    chk("stl_head_c", out_data, 32'hC);
    chk("stl_c_level", {30'd0, level}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    chk("stl_empty", {31'd0, out_valid}, 32'd0);
    $display("stall: order A,B,C drained, level=%0d", level);

    // Flush while FULL
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    next_cycle();
    chk("fl_full_level", {30'd0, level}, 32'd2);
    drive(1'b1, 32'h33, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_level", {30'd0, level}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();
    chk("fl_no_33", {31'd0, out_valid}, 32'd0);
    $display("flush-full: out_valid=%0b level=%0d", out_valid, level);

    // Flush together with pop
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    next_cycle();
    chk("fp_busy", out_data, 32'h44);
    drive(1'b1, 32'h55, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fp_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fp_level", {30'd0, level}, 32'd0);
    next_cycle();
    chk("fp_no_55", {31'd0, out_valid}, 32'd0);
    $display("flush-pop: out_valid=%0b level=%0d", out_valid, level);

    // Random traffic; every 16th cycle probe in_ready for a combinational path from out_ready
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
      if ((c % 16) == 0) begin
        automatic logic ir = in_ready;
        out_ready = ~out_ready;
        #1;
        chk("rnd_in_ready_comb", {31'd0, in_ready}, {31'd0, ir});
        out_ready = ~out_ready;
      end
      next_cycle();
    end
    $display("random: 10000 cycles done, level=%0d", level);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_pipe_skid.md
# ysyx_24100029_pipe_skid

Two-entry valid/ready pipeline stage that sits between CPU pipeline stages (IFU→IDU→EXU→LSU→WBU) and owns the consumer side of the stage-register write-enable protocol. Upstream offers beats with `in_valid`. The block accepts them into a main register plus a skid register, and presents them downstream with `out_valid` until `out_ready`. It decouples the upstream `in_ready` from the downstream `out_ready` combinational path while sustaining one beat per cycle. It also supports a pipeline flush for branch or exception redirect.

## Interface
Parameters:
- `WIDTH`, 32, payload width in bits.
- `RESET_VAL`, 0, reset value of the main and skid data registers.

Ports:
- `clock`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held beats and any beat offered this cycle.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  block can accept a beat; registered, no combinational path from any input.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid beat; registered.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  WIDTH  payload; driven directly from the main register.
- `level`  out  2  occupancy, 0..2; registered.

## Operation
- Accept condition is `in_valid & in_ready`. Pop condition is `out_valid & out_ready`.
- State encoding:
  - EMPTY: `level`=0, `out_valid`=0, `in_ready`=1.
  - BUSY: `level`=1, `out_valid`=1, `in_ready`=1.
  - FULL: `level`=2, `out_valid`=1, `in_ready`=0.
- EMPTY:
  - accept: main←`in_data`, go to BUSY.
  - otherwise: stay.
- BUSY:
  - accept and pop: main←`in_data`, stay in BUSY.
  - accept without pop: skid←`in_data`, go to FULL.
  - pop without accept: go to EMPTY.
  - neither: stay.
- FULL:
  - pop: main←skid, go to BUSY. No accept is possible because `in_ready`=0.
  - no pop: stay; main and skid hold.
- Beats leave in strict acceptance order. No beat is dropped or duplicated except on flush.
- Flush has priority over every other event:
  - The next state is EMPTY from any state.
  - A beat offered in the flush cycle is discarded even if `in_valid & in_ready`.
  - A pop in the flush cycle still counts as consumed downstream.
  - The data registers are not cleared; `out_data` holds its stale value while `out_valid`=0.
- While `out_valid`=0, `out_data` is don't-care for consumers, but it must equal the last main-register value (no X after reset).
- `in_data` is sampled only on accept. `out_ready` is honoured only while `out_valid`=1.
- Reset overrides flush and all handshakes.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1, `level`=0.
  - main=skid=`RESET_VAL`, so `out_data`=`RESET_VAL`.
  - These values are visible in the cycle after the reset edge and remain while `reset` stays high.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N; minimum 1 cycle, no bypass.
- Throughput: with `out_ready` held high, one beat per cycle indefinitely; `in_ready` stays 1.
- Backpressure: if `out_ready` falls while BUSY and a beat is accepted, the skid captures it. `in_ready` drops after that same edge, so at most one beat is accepted after the stall.
- Release: from FULL, a pop returns the state to BUSY and `in_ready` is 1 after the same edge. Upstream can resume on the following cycle.
- Flush is effective after one edge: `out_valid`=0, `level`=0, `in_ready`=1.
- Reset or flush mid-stream: no partial beat survives.
- `level` always equals the population count of the valid entries. 3 is never produced.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid`=1. Required after release:
  - `out_valid`=0, `in_ready`=1, `level`=0.
  - `out_data`=`RESET_VAL` (test with `RESET_VAL`=32'hDEAD_BEEF).
- Streaming: send 0x1..0x8 on consecutive cycles with `out_ready`=1. Required:
  - outputs 0x1..0x8 on consecutive cycles, each 1 cycle after its accept.
  - `in_ready` never drops; `level`=1 throughout.
- Stall/skid:
  - Stimulus: accept 0xA, then drop `out_ready` while offering 0xB and 0xC.
  - Required: 0xB is accepted, `level`=2, `in_ready`=0, 0xC is held off.
  - Then raise `out_ready`. Required order 0xA, 0xB, 0xC, with no loss or duplication.
- Flush in FULL:
  - Stimulus: in FULL with 0x11 and 0x22 held, assert `flush` while offering 0x33.
  - Required next cycle: `out_valid`=0, `level`=0, `in_ready`=1; 0x33 never appears.
- Flush and pop together:
  - Stimulus: in BUSY holding 0x44, assert `out_ready`=1 and `flush`=1 with `in_valid`=1, data 0x55.
  - Required next cycle: EMPTY; 0x55 is dropped.
- Random: random `in_valid`/`out_ready` at 50% for 10k cycles against a reference queue. Required:
  - in-order delivery.
  - `level` matches the model.
  - `in_ready` never has a combinational dependence on `out_ready`.
